// File: rtl/coraz7_btn_debouncer.sv
// Push-button conditioner for the Cora Z7 wrapper: per channel, a pad
// synchronizer, a stable-time debouncer, press/release pulses and a sticky
// press flag. All outputs are registered; channels share nothing.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   btn_raw       raw pad inputs (asynchronous, active-high)
//   btn_level     debounced button level
//   btn_press     one-cycle pulse, high in the first cycle btn_level reads 1
//   btn_release   one-cycle pulse, high in the first cycle btn_level reads 0
//   press_pending sticky press flag, cleared by press_clear (set wins)
//   press_clear   per-bit clear strobe for press_pending
module coraz7_btn_debouncer #(
  parameter int unsigned NUM_BTNS        = 2,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1250000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release,
  output logic [NUM_BTNS-1:0] press_pending,
  input  logic [NUM_BTNS-1:0] press_clear
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   flip;
    logic                   level_q;
    logic                   press_q;
    logic                   release_q;
    logic                   pending_q;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Stable-time counter: restarts whenever the input agrees with the
    // current level, flips the level on the terminal count, never wraps.
    always_comb begin
      cnt_d = '0;
      flip  = 1'b0;
      if (sync_out != level_q) begin
        if (cnt_q == CNT_MAX) begin
          flip = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    // Pulses are registered on the same edge as the level change, so they
    // line up with the first cycle the new level is visible. The pending
    // flag is set from the registered press pulse; set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q    <= '0;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        pending_q <= 1'b0;
      end else begin
        sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_raw[i]};
        cnt_q     <= cnt_d;
        if (flip) begin
          level_q <= sync_out;
        end
        press_q   <= flip & sync_out;
        release_q <= flip & ~sync_out;
        pending_q <= press_q | (pending_q & ~press_clear[i]);
      end
    end

    assign btn_level[i]     = level_q;
    assign btn_press[i]     = press_q;
    assign btn_release[i]   = release_q;
    assign press_pending[i] = pending_q;
  end

endmodule

// File: tb/tb_coraz7_btn_debouncer.sv
// Directed bench for coraz7_btn_debouncer with SYNC_STAGES=2,
// DEBOUNCE_CYCLES=8, NUM_BTNS=2 (level change 10 edges after a raw change).
module tb_coraz7_btn_debouncer;

  logic       clk;
  logic       rst_n;
  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic [1:0] press_pending;
  logic [1:0] press_clear;

  int checks = 0;
  int errors = 0;

  coraz7_btn_debouncer #(
    .NUM_BTNS        (2),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_raw       (btn_raw),
    .btn_level     (btn_level),
    .btn_press     (btn_press),
    .btn_release   (btn_release),
    .press_pending (press_pending),
    .press_clear   (press_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int press_cnt;
    int p0_cnt;
    int p1_cnt;
    int p0_at;
    int p1_at;
    int both_err;

    rst_n       = 1'b0;
    btn_raw     = 2'b00;
    press_clear = 2'b00;
    repeat (3) step();
    check("reset_level",   32'(btn_level),     32'h0);
    check("reset_press",   32'(btn_press),     32'h0);
    check("reset_release", 32'(btn_release),   32'h0);
    check("reset_pending", 32'(press_pending), 32'h0);
    rst_n = 1'b1;
    repeat (3) step();

    // Clean press on channel 0
    btn_raw = 2'b01;
    repeat (9) step();
    check("press_edge9_level", 32'(btn_level), 32'h0);
    check("press_edge9_press", 32'(btn_press), 32'h0);
    step();
    check("press_edge10_level",   32'(btn_level),   32'h1);
    check("press_edge10_press",   32'(btn_press),   32'h1);
    check("press_edge10_release", 32'(btn_release), 32'h0);
    step();
    check("press_after_press",   32'(btn_press),     32'h0);
    check("press_after_pending", 32'(press_pending), 32'h1);
    check("press_after_level",   32'(btn_level),     32'h1);

    // Release on channel 0
    btn_raw = 2'b00;
    repeat (9) step();
    check("rel_edge9_level", 32'(btn_level), 32'h1);
    step();
    check("rel_edge10_level",   32'(btn_level),     32'h0);
    check("rel_edge10_release", 32'(btn_release),   32'h1);
    check("rel_edge10_press",   32'(btn_press),     32'h0);
    check("rel_edge10_pending", 32'(press_pending), 32'h1);
    step();
    check("rel_after_release", 32'(btn_release),   32'h0);
    check("rel_after_pending", 32'(press_pending), 32'h1);

    // Clear the flag, then clear again while it is already 0
    press_clear = 2'b01;
    step();
    press_clear = 2'b00;
    check("clear_pending", 32'(press_pending), 32'h0);
    press_clear = 2'b01;
    step();
    press_clear = 2'b00;
    check("clear_idle_pending", 32'(press_pending), 32'h0);

    // Bounce: 3-cycle runs for 40 cycles, then hold 1
    press_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      btn_raw[0] = ((c / 3) % 2 == 0) ? 1'b1 : 1'b0;
      step();
      press_cnt += int'(btn_press[0]);
    end
    check("bounce_level_during", 32'(btn_level), 32'h0);
    btn_raw[0] = 1'b1;
    repeat (9) begin
      step();
      press_cnt += int'(btn_press[0]);
    end
    check("bounce_edge9_level", 32'(btn_level), 32'h0);
    step();
    press_cnt += int'(btn_press[0]);
    check("bounce_edge10_press", 32'(btn_press), 32'h1);
    check("bounce_edge10_level", 32'(btn_level), 32'h1);
    repeat (5) begin
      step();
      press_cnt += int'(btn_press[0]);
    end
    check("bounce_press_count", 32'(press_cnt), 32'd1);

    // Return channel 0 to 0 before the reset test
    btn_raw = 2'b00;
    repeat (12) step();
    check("pre_reset_level",   32'(btn_level),     32'h0);
    check("pre_reset_pending", 32'(press_pending), 32'h1);

    // Reset in the middle of a count
    btn_raw = 2'b01;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    check("midrst_level",   32'(btn_level),     32'h0);
    check("midrst_press",   32'(btn_press),     32'h0);
    check("midrst_release", 32'(btn_release),   32'h0);
    check("midrst_pending", 32'(press_pending), 32'h0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (9) step();
    check("postrst_edge9_press", 32'(btn_press), 32'h0);
    check("postrst_edge9_level", 32'(btn_level), 32'h0);
    step();
    check("postrst_edge10_press", 32'(btn_press), 32'h1);
    check("postrst_edge10_level", 32'(btn_level), 32'h1);
    step();
    check("postrst_pending", 32'(press_pending), 32'h1);

    // Clear/set collision on channel 1
    btn_raw = 2'b11;
    repeat (10) step();
    check("coll_press", 32'(btn_press), 32'h2);
    press_clear = 2'b10;
    step();
    check("coll_set_wins", 32'(press_pending), 32'h3);
    step();
    press_clear = 2'b00;
    check("coll_next_clear", 32'(press_pending), 32'h1);

    // Independence: presses 3 cycles apart
    btn_raw = 2'b00;
    repeat (12) step();
    check("indep_idle_level", 32'(btn_level), 32'h0);
    press_clear = 2'b11;
    step();
    press_clear = 2'b00;
    p0_cnt = 0; p1_cnt = 0; p0_at = 0; p1_at = 0; both_err = 0;
    btn_raw[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 3) btn_raw[1] = 1'b1;
      if (btn_press[0]) begin p0_cnt++; p0_at = k; end
      if (btn_press[1]) begin p1_cnt++; p1_at = k; end
      if ((btn_press & btn_release) != 2'b00) both_err++;
    end
    check("indep_p0_count", 32'(p0_cnt), 32'd1);
    check("indep_p1_count", 32'(p1_cnt), 32'd1);
    check("indep_p0_at",    32'(p0_at),  32'd10);
    check("indep_spacing",  32'(p1_at - p0_at), 32'd3);
    check("indep_no_both",  32'(both_err), 32'd0);
    check("indep_pending",  32'(press_pending), 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
